// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared fetch FSM type, flash constants and sample scaling
package audio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DATA,
    PUSH_LO,
    PUSH_HI
  } fetch_state_t;

  localparam int         FLASH_ADDR_W = 23;
  localparam logic [3:0] FLASH_BE_ALL = 4'b1111;

  // Signed divide by 2^shift rounding toward zero: negative values are biased
  // up by (2^shift - 1) before the arithmetic shift so -1 becomes 0, not -1.
  function automatic logic signed [15:0] scale_sample(logic signed [15:0] x, int shift);
    int v;
    v = int'(x);
    if (v < 0) begin
      v = v + ((1 << shift) - 1);
    end
    return 16'(v >>> shift);
  endfunction

endpackage

// File: rtl/flash_sample_fetcher_if.sv
// rtl/flash_sample_fetcher_if.sv - flash read bus plus sample stream bundle
interface flash_sample_fetcher_if;
  import audio_pkg::*;

  logic                    flash_mem_read;
  logic [FLASH_ADDR_W-1:0] flash_mem_address;
  logic [3:0]              flash_mem_byteenable;
  logic                    flash_mem_waitrequest;
  logic [31:0]             flash_mem_readdata;
  logic                    flash_mem_readdatavalid;

  logic [15:0]             sample_data;
  logic                    sample_valid;
  logic                    sample_ready;

  // Fetcher side: drives the flash request and produces samples.
  modport master (
    output flash_mem_read,
    output flash_mem_address,
    output flash_mem_byteenable,
    input  flash_mem_waitrequest,
    input  flash_mem_readdata,
    input  flash_mem_readdatavalid,
    output sample_data,
    output sample_valid,
    input  sample_ready
  );

  // Flash slave and sample consumer side.
  modport slave (
    input  flash_mem_read,
    input  flash_mem_address,
    input  flash_mem_byteenable,
    output flash_mem_waitrequest,
    output flash_mem_readdata,
    output flash_mem_readdatavalid,
    input  sample_data,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous first-word-fall-through FIFO with occupancy count
module sample_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     CLOCK_50,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pushes into a full FIFO and pops from an empty one are dropped.
  assign do_push = push && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);

  // Head is forced to zero while empty so the output is defined after reset.
  assign head_valid = (count != '0);
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping; simultaneous push and pop cancel out.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge CLOCK_50) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/flash_sample_fetcher.sv
// rtl/flash_sample_fetcher.sv - flash read master feeding scaled samples to a FIFO
module flash_sample_fetcher
  import audio_pkg::*;
#(
  parameter int NUM_WORDS  = 1048576,
  parameter int FIFO_DEPTH = 8,
  parameter int SHIFT      = 6
) (
  input  logic                   CLOCK_50,
  input  logic                   rst_n,
  input  logic                   enable,
  output logic                   done,
  flash_sample_fetcher_if.master bus
);

  localparam int                      CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FLASH_ADDR_W-1:0] LAST_ADDR = FLASH_ADDR_W'(NUM_WORDS - 1);

  fetch_state_t            state_q;
  fetch_state_t            state_d;
  logic [31:0]             word_q;
  logic [FLASH_ADDR_W-1:0] addr_q;
  logic                    read_req;
  logic                    push;
  logic [15:0]             push_data;
  logic [CNT_W-1:0]        fifo_count;
  logic                    has_room;

  // Both halves of a word must fit before a read is issued, so pushes never stall.
  assign has_room = (CNT_W'(FIFO_DEPTH) - fifo_count) >= CNT_W'(2);

  assign bus.flash_mem_read       = read_req;
  assign bus.flash_mem_address    = addr_q;
  assign bus.flash_mem_byteenable = FLASH_BE_ALL;

  // Fetch state register.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state outputs; once issued a read always runs to completion.
  always_comb begin
    state_d   = state_q;
    read_req  = 1'b0;
    push      = 1'b0;
    push_data = '0;
    case (state_q)
      IDLE: begin
        if (enable && has_room) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        read_req = 1'b1;
        if (!bus.flash_mem_waitrequest) begin
          state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (bus.flash_mem_readdatavalid) begin
          state_d = PUSH_LO;
        end
      end
      PUSH_LO: begin
        push      = 1'b1;
        push_data = scale_sample($signed(word_q[15:0]), SHIFT);
        state_d   = PUSH_HI;
      end
      PUSH_HI: begin
        push      = 1'b1;
        push_data = scale_sample($signed(word_q[31:16]), SHIFT);
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture returned data, step the word address and flag the first wrap.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      word_q <= '0;
      addr_q <= '0;
      done   <= 1'b0;
    end else begin
      if (state_q == WAIT_DATA && bus.flash_mem_readdatavalid) begin
        word_q <= bus.flash_mem_readdata;
      end
      if (state_q == PUSH_HI) begin
        if (addr_q == LAST_ADDR) begin
          addr_q <= '0;
          done   <= 1'b1;
        end else begin
          addr_q <= addr_q + 1'b1;
        end
      end
    end
  end

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .CLOCK_50   (CLOCK_50),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (push_data),
    .pop        (bus.sample_ready),
    .head_data  (bus.sample_data),
    .head_valid (bus.sample_valid),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_flash_sample_fetcher.sv
// tb/tb_flash_sample_fetcher.sv - directed self-checking bench for flash_sample_fetcher
module tb_flash_sample_fetcher;

  typedef struct {
    logic [31:0] word;
    logic [15:0] exp_lo;
    logic [15:0] exp_hi;
  } vec_t;

  logic CLOCK_50 = 1'b0;
  logic rst_n;
  logic enable;
  logic done;

  flash_sample_fetcher_if bus_if ();

  flash_sample_fetcher #(
    .NUM_WORDS  (4),
    .FIFO_DEPTH (8),
    .SHIFT      (6)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .enable   (enable),
    .done     (done),
    .bus      (bus_if.master)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Flash model: configurable wait states and read latency, one read at a time.
  int          ws_cfg;
  int          lat_cfg;
  int          ws_cnt;
  int          lat_cnt;
  int          reads_issued;
  int          addr_log[$];
  logic        m_rdv;
  logic        man_rdv;
  logic [31:0] m_rdata;
  logic [1:0]  pend_idx;
  logic [31:0] mem [4];

  assign bus_if.flash_mem_waitrequest   = bus_if.flash_mem_read && (ws_cnt < ws_cfg);
  assign bus_if.flash_mem_readdatavalid = m_rdv | man_rdv;
  assign bus_if.flash_mem_readdata      = m_rdata;

  always @(posedge CLOCK_50) begin
    if (!rst_n) begin
      ws_cnt       <= 0;
      lat_cnt      <= 0;
      m_rdv        <= 1'b0;
      m_rdata      <= '0;
      reads_issued <= 0;
      addr_log.delete();
    end else begin
      m_rdv <= 1'b0;
      if (bus_if.flash_mem_read) begin
        if (ws_cnt < ws_cfg) begin
          ws_cnt <= ws_cnt + 1;
        end else begin
          ws_cnt       <= 0;
          reads_issued <= reads_issued + 1;
          addr_log.push_back(int'(bus_if.flash_mem_address));
          pend_idx     <= bus_if.flash_mem_address[1:0];
          if (lat_cfg <= 1) begin
            m_rdv   <= 1'b1;
            m_rdata <= mem[bus_if.flash_mem_address[1:0]];
          end else begin
            lat_cnt <= lat_cfg - 1;
          end
        end
      end
      if (lat_cnt == 1) begin
        m_rdv   <= 1'b1;
        m_rdata <= mem[pend_idx];
      end
      if (lat_cnt > 0) begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl [4];

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait (bounded) for a sample, compare it, then pop it.
  task automatic pop_expect(input string name, input logic [15:0] exp);
    for (int i = 0; i < 50 && !bus_if.sample_valid; i++) tick();
    check({name, "_valid"}, 32'(bus_if.sample_valid), 32'd1);
    check(name, 32'(bus_if.sample_data), 32'(exp));
    bus_if.sample_ready = 1'b1;
    tick();
    bus_if.sample_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    tbl[0] = '{32'hFFC0_0040, 16'h0001, 16'hFFFF};
    tbl[1] = '{32'h8000_FFBF, 16'hFFFF, 16'hFE00};
    tbl[2] = '{32'h7FFF_FFFF, 16'h0000, 16'h01FF};
    tbl[3] = '{32'hFF80_0080, 16'h0002, 16'hFFFE};
    for (int i = 0; i < 4; i++) mem[i] = tbl[i].word;

    man_rdv             = 1'b0;
    bus_if.sample_ready = 1'b0;
    ws_cfg              = 1;
    lat_cfg             = 2;
    enable              = 1'b1;

    // Reset values with enable held high through reset.
    do_reset();
    check("rst_read", 32'(bus_if.flash_mem_read), 32'd0);
    check("rst_addr", 32'(bus_if.flash_mem_address), 32'd0);
    check("rst_valid", 32'(bus_if.sample_valid), 32'd0);
    check("rst_data", 32'(bus_if.sample_data), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_be", 32'(bus_if.flash_mem_byteenable), 32'hF);

    // Basic read: 1 wait state, 2-cycle latency, then drain.
    rst_n = 1'b1;
    tick();
    check("first_read", 32'(bus_if.flash_mem_read), 32'd1);
    enable = 1'b0;
    for (int i = 0; i < 20 && !bus_if.flash_mem_readdatavalid; i++) tick();
    check("basic_rdv_seen", 32'(bus_if.flash_mem_readdatavalid), 32'd1);
    check("lat_t0_valid", 32'(bus_if.sample_valid), 32'd0);
    tick();
    check("lat_t1_valid", 32'(bus_if.sample_valid), 32'd0);
    tick();
    check("lat_t2_valid", 32'(bus_if.sample_valid), 32'd1);
    check("basic_lo", 32'(bus_if.sample_data), 32'h0001);
    tick();
    check("basic_addr", 32'(bus_if.flash_mem_address), 32'd1);
    check("basic_done", 32'(done), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("basic_idle_read", 32'(bus_if.flash_mem_read), 32'd0);
    check("basic_reads", 32'(reads_issued), 32'd1);
    pop_expect("basic_s0", 16'h0001);
    pop_expect("basic_s1", 16'hFFFF);
    check("basic_empty", 32'(bus_if.sample_valid), 32'd0);

    // Table pass: zero waits, 1-cycle latency, consumer stalled until FIFO fills.
    do_reset();
    ws_cfg  = 0;
    lat_cfg = 1;
    rst_n   = 1'b1;
    enable  = 1'b1;
    for (int i = 0; i < 60; i++) tick();
    check("bp_reads", 32'(reads_issued), 32'd4);
    check("bp_read_low", 32'(bus_if.flash_mem_read), 32'd0);
    check("wrap_done", 32'(done), 32'd1);
    check("wrap_addr", 32'(bus_if.flash_mem_address), 32'd0);

    pop_expect("bp_pop1", tbl[0].exp_lo);
    for (int i = 0; i < 10; i++) tick();
    check("bp_one_pop_reads", 32'(reads_issued), 32'd4);
    check("bp_one_pop_read", 32'(bus_if.flash_mem_read), 32'd0);
    pop_expect("bp_pop2", tbl[0].exp_hi);
    for (int i = 0; i < 20 && reads_issued < 5; i++) tick();
    check("bp_two_pop_reads", 32'(reads_issued), 32'd5);

    for (int w = 1; w < 4; w++) begin
      pop_expect($sformatf("p1_w%0d_lo", w), tbl[w].exp_lo);
      pop_expect($sformatf("p1_w%0d_hi", w), tbl[w].exp_hi);
    end
    for (int w = 0; w < 4; w++) begin
      pop_expect($sformatf("p2_w%0d_lo", w), tbl[w].exp_lo);
      pop_expect($sformatf("p2_w%0d_hi", w), tbl[w].exp_hi);
    end
    check("pass2_done", 32'(done), 32'd1);
    check("addr_log_len", 32'(addr_log.size() >= 5), 32'd1);
    if (addr_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("addr_seq_%0d", i), 32'(addr_log[i]), 32'(i % 4));
      end
    end

    // Enable drops during ISSUE while waitrequest is held for 3 cycles.
    enable = 1'b0;
    do_reset();
    ws_cfg  = 3;
    lat_cfg = 1;
    rst_n   = 1'b1;
    check("ed_done_clr", 32'(done), 32'd0);
    enable = 1'b1;
    for (int i = 0; i < 10 && !bus_if.flash_mem_read; i++) tick();
    check("ed_in_issue", 32'(bus_if.flash_mem_read), 32'd1);
    enable = 1'b0;
    tick();
    check("ed_read_held", 32'(bus_if.flash_mem_read), 32'd1);
    for (int i = 0; i < 20; i++) tick();
    check("ed_reads", 32'(reads_issued), 32'd1);
    check("ed_read_low", 32'(bus_if.flash_mem_read), 32'd0);
    check("ed_addr", 32'(bus_if.flash_mem_address), 32'd1);
    pop_expect("ed_lo", tbl[0].exp_lo);
    pop_expect("ed_hi", tbl[0].exp_hi);
    check("ed_empty", 32'(bus_if.sample_valid), 32'd0);

    // Reset while waiting for read data; a late strobe must be ignored.
    do_reset();
    ws_cfg  = 0;
    lat_cfg = 6;
    rst_n   = 1'b1;
    enable  = 1'b1;
    for (int i = 0; i < 10 && !bus_if.flash_mem_read; i++) tick();
    check("mr_in_issue", 32'(bus_if.flash_mem_read), 32'd1);
    tick();
    check("mr_accepted", 32'(bus_if.flash_mem_read), 32'd0);
    enable = 1'b0;
    rst_n  = 1'b0;
    tick();
    check("mr_read", 32'(bus_if.flash_mem_read), 32'd0);
    check("mr_addr", 32'(bus_if.flash_mem_address), 32'd0);
    check("mr_valid", 32'(bus_if.sample_valid), 32'd0);
    check("mr_data", 32'(bus_if.sample_data), 32'd0);
    check("mr_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    man_rdv = 1'b1;
    tick();
    man_rdv = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("mr_late_valid", 32'(bus_if.sample_valid), 32'd0);
    check("mr_late_read", 32'(bus_if.flash_mem_read), 32'd0);
    check("mr_late_addr", 32'(bus_if.flash_mem_address), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
